// File: rtl/divider.sv
// Sequential restoring shift-subtract divider.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and produces one
// quotient bit per clock. Overflow is flagged when the quotient cannot fit
// in WIDTH bits, which includes a zero divisor.
module divider #(
  parameter int WIDTH = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor_q;
  // The partial remainder is held in WIDTH bits only: it always stays below
  // the divisor, so its extra top bit would always be zero.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] s_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             trial_ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] s_next;

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor and keep the difference when it does not borrow. With the
  // remainder below the divisor the trial is below twice the divisor, so a
  // WIDTH+1-bit subtraction is exact and its top bit is the borrow.
  always_comb begin
    trial    = {r_reg, s_reg[WIDTH-1]};
    diff     = trial - {1'b0, divisor_q};
    trial_ge = ~diff[WIDTH];
    r_next   = trial_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    s_next   = {s_reg[WIDTH-2:0], trial_ge};
  end

  // Control FSM with registered results; IDLE and DONE both accept a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      divisor_q <= '0;
      r_reg     <= '0;
      s_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            divisor_q <= divisor;
            r_reg     <= dividend[2*WIDTH-1:WIDTH];
            s_reg     <= dividend[WIDTH-1:0];
            busy      <= 1'b1;
            done      <= 1'b0;
            overflow  <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (r_reg >= divisor_q) begin
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            count <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          r_reg <= r_next;
          s_reg <= s_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            quotient  <= s_next;
            remainder <= r_next;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential restoring shift-subtract divider; the inverse of the existing shift-and-add multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing one quotient bit per clock.
- Serves the CPU core's DIV instruction path, which pairs with MPY on the multiplier. It produces a WIDTH-bit quotient and remainder, or flags overflow when the quotient cannot fit.

Parameters:
WIDTH, 18, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while idle (busy=0)
dividend  input  2*WIDTH  numerator, latched on accepted start
divisor  input  WIDTH  denominator, latched on accepted start
quotient  output  WIDTH  result quotient, valid while done=1
remainder  output  WIDTH  result remainder, valid while done=1
busy  output  1  operation in progress
done  output  1  result valid; level, held until next accepted start
overflow  output  1  qualifies done: quotient does not fit or divisor is 0

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE.
  - quotient=0, remainder=0, busy=0, done=0, overflow=0, iteration counter=0.
  - Reset mid-operation aborts the division; no partial result is presented.
- States are IDLE, CHECK, ITER and DONE. DONE behaves as IDLE for start acceptance.
- IDLE/DONE, start=1 at edge N:
  - Latch dividend and divisor.
  - Load the partial remainder R (WIDTH+1 bits) = {0, dividend[2W-1:W]}.
  - Load the shift register S = dividend[W-1:0].
  - Set busy=1, done=0, overflow=0. Go to CHECK.
- CHECK, edge N+1, overflow test:
  - Overflow if R[W-1:0] >= divisor. This includes divisor=0.
  - If overflow: quotient=0, remainder=0, overflow=1, done=1, busy=0; go to DONE. Latency is 2 edges from start.
  - Otherwise: counter=0; go to ITER.
- ITER, one bit per edge, WIDTH iterations (edges N+2 .. N+W+1):
  - T = {R[W-1:0], S[W-1]}.
  - If T >= {0,divisor}: R=T-divisor and qbit=1. Else R=T and qbit=0.
  - S = {S[W-2:0], qbit}; counter increments.
  - On the iteration with counter=W-1: quotient=S_new, remainder=R_new[W-1:0], done=1, busy=0; go to DONE.
- Total latency with no overflow: done rises at edge N+W+1, which is 19 edges after the start edge for W=18.
- Width rules:
  - R < divisor holds invariantly, so T < 2*divisor fits in W+1 bits.
  - The final R < divisor fits in W bits.
  - The unsigned compare uses W+1 bits.
- start while busy=1 is ignored. The latched operands are unaffected.
- Input operands may change freely after the start edge; only the latched copies are used.
- start held high in DONE begins a new operation every time the block returns to DONE.
- In DONE, quotient/remainder/overflow hold until the next accepted start. The clearing of done and overflow on that start happens at the same edge.

Test Plan:
- dividend=100, divisor=7, one-cycle start -> busy=1 for 19 edges; then done=1, quotient=14, remainder=2, overflow=0.
- dividend=36'hFFFFBFFFF, divisor=18'h3FFFF -> quotient=18'h3FFFF, remainder=18'h3FFFE, overflow=0 (maximum quotient without overflow).
- dividend=36'h000140000, divisor=5 -> overflow=1, done=1 two edges after start, quotient=0, remainder=0. Repeat with divisor=6 -> quotient=18'h35555, remainder=2, overflow=0.
- divisor=0, any dividend -> overflow=1, done=1 at start+2 edges, busy never exceeds 2 cycles.
- Start 100/7, then at edge +5 pulse start with 50/3 and change the input buses -> ignored; result still 14 r 2. After done, start 50/3 -> done clears, then 16 r 2.
- Start 100/7, assert reset_n=0 at edge +10 -> all outputs 0 immediately (async). After release, idle with done=0. A new start 9/4 -> quotient 2, remainder 1.
